// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared opcode, ALU and mux encodings plus the sequencer
//                state type for the multi-cycle MIPS control path.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OPCODE_LW    = 6'b100011;
    localparam logic [5:0] OPCODE_SW    = 6'b101011;
    localparam logic [5:0] OPCODE_BEQ   = 6'b000100;
    localparam logic [5:0] OPCODE_ADDI  = 6'b001000;
    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // ALU B-operand mux encodings
    localparam logic [1:0] SRCB_REG  = 2'b00;  // register B
    localparam logic [1:0] SRCB_FOUR = 2'b01;  // constant 4
    localparam logic [1:0] SRCB_IMM  = 2'b10;  // sign-extended immediate
    localparam logic [1:0] SRCB_BR   = 2'b11;  // sign-extended immediate << 2

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Combinational opcode-to-class decode. Exactly one class
//                flag is high for any opcode; is_bad covers everything the
//                sequencer does not implement.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter logic [5:0] OP_LW    = OPCODE_LW,
    parameter logic [5:0] OP_SW    = OPCODE_SW,
    parameter logic [5:0] OP_BEQ   = OPCODE_BEQ,
    parameter logic [5:0] OP_ADDI  = OPCODE_ADDI,
    parameter logic [5:0] OP_RTYPE = OPCODE_RTYPE
) (
    input  logic [5:0] opcode,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_addi,
    output logic       is_r,
    output logic       is_bad
);

    // Classify the opcode; anything unrecognised is flagged as bad
    always_comb begin
        is_lw   = (opcode == OP_LW);
        is_sw   = (opcode == OP_SW);
        is_beq  = (opcode == OP_BEQ);
        is_addi = (opcode == OP_ADDI);
        is_r    = (opcode == OP_RTYPE);
        is_bad  = !(is_lw || is_sw || is_beq || is_addi || is_r);
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle MIPS sequencer. Shares one ALU and one memory
//                port across FETCH/DECODE/EXEC/MEM/WB, drives the datapath
//                strobes and muxes, and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int          CNT_W    = 32,
    parameter logic [5:0]  OP_LW    = OPCODE_LW,
    parameter logic [5:0]  OP_SW    = OPCODE_SW,
    parameter logic [5:0]  OP_BEQ   = OPCODE_BEQ,
    parameter logic [5:0]  OP_ADDI  = OPCODE_ADDI,
    parameter logic [5:0]  OP_RTYPE = OPCODE_RTYPE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             mem_ack,
    input  logic             alu_zero,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    logic w_is_lw, w_is_sw, w_is_beq, w_is_addi, w_is_r, w_is_bad;

    // Only the opcode and the low funct nibble steer the sequencer
    logic w_unused_instr;
    assign w_unused_instr = ^instruction[25:4];

    ctrl_decode #(
        .OP_LW    (OP_LW),
        .OP_SW    (OP_SW),
        .OP_BEQ   (OP_BEQ),
        .OP_ADDI  (OP_ADDI),
        .OP_RTYPE (OP_RTYPE)
    ) u_decode (
        .opcode  (instruction[31:26]),
        .is_lw   (w_is_lw),
        .is_sw   (w_is_sw),
        .is_beq  (w_is_beq),
        .is_addi (w_is_addi),
        .is_r    (w_is_r),
        .is_bad  (w_is_bad)
    );

    // State register; reset aborts any phase, dropping mem_req at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;

    // Next-state and output decode; Mealy strobes on mem_ack / alu_zero
    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_ctrl   = 4'b0000;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;

        case (r_state)
            IDLE: begin
                w_next = FETCH;
            end

            FETCH: begin
                // ALU computes PC+4 while memory returns the instruction
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctrl  = ALU_ADD;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = DECODE;
                end
            end

            DECODE: begin
                // Speculative branch target lands in ALUOut
                alu_src_b = SRCB_BR;
                alu_ctrl  = ALU_ADD;
                w_next    = EXEC;
            end

            EXEC: begin
                if (w_is_lw || w_is_sw || w_is_addi) begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = ALU_ADD;
                    w_next    = w_is_addi ? WB : MEM;
                end else if (w_is_r) begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_REG;
                    alu_ctrl  = instruction[3:0];
                    w_next    = WB;
                end else if (w_is_beq) begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_REG;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 1'b1;
                    pc_write  = alu_zero;
                    w_retire  = 1'b1;
                    w_next    = FETCH;
                end else begin
                    // PC has already advanced, so simply resume fetching
                    illegal = w_is_bad;
                    w_next  = FETCH;
                end
            end

            MEM: begin
                // Request and direction stay constant until acknowledged
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = w_is_sw;
                if (mem_ack) begin
                    if (w_is_sw) begin
                        w_retire = 1'b1;
                        w_next   = FETCH;
                    end else begin
                        w_next = WB;
                    end
                end
            end

            WB: begin
                reg_write  = 1'b1;
                reg_dst    = w_is_r;
                mem_to_reg = w_is_lw;
                w_retire   = 1'b1;
                w_next     = FETCH;
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. Each instruction is
//                expanded into its expected per-cycle control trace from its
//                class and memory wait counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int CW = 4;

    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_R    = 6'b000000;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instruction;
    logic          mem_ack;
    logic          alu_zero;
    logic          mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [3:0]    alu_ctrl;
    logic          reg_write, reg_dst, mem_to_reg, illegal;
    logic [CW-1:0] retired;

    int            checks = 0;
    int            errors = 0;
    int            ncyc   = 0;
    logic [CW-1:0] m_ret  = '0;

    logic [16:0]   obs;
    assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg, illegal};

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .mem_ack     (mem_ack),
        .alu_zero    (alu_zero),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .i_or_d      (i_or_d),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_ctrl    (alu_ctrl),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .illegal     (illegal),
        .retired     (retired)
    );

    // Build an expected control vector from named fields
    function automatic logic [16:0] v(input logic req, we, iord, irw, pcw, pcs, sa,
                                      input logic [1:0] sb, input logic [3:0] ac,
                                      input logic rw, rd, m2r, ill);
        return {req, we, iord, irw, pcw, pcs, sa, sb, ac, rw, rd, m2r, ill};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Entered at posedge+1: drive inputs, check mid-cycle, advance one clock
    task automatic step(input logic [16:0] exp, input logic ack, input logic zero,
                        input string tag);
        mem_ack  = ack;
        alu_zero = zero;
        #4;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic chk_ret(input string tag);
        checks++;
        assert (retired === m_ret) else begin
            errors++;
            $error("FAIL %s: observed retired %0d expected %0d", tag, retired, m_ret);
        end
    endtask

    // Run one instruction end to end with the given memory wait counts
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic zero);
        logic [5:0] op;
        int         lat;
        op          = ins[31:26];
        instruction = ins;
        ncyc        = 0;
        for (int i = 0; i < fw; i++)
            step(v(1,0,0,0,0,0,0,2'b01,4'b0010,0,0,0,0), 1'b0, rbit(), "fetch_wait");
        step(v(1,0,0,1,1,0,0,2'b01,4'b0010,0,0,0,0), 1'b1, rbit(), "fetch_ack");
        step(v(0,0,0,0,0,0,0,2'b11,4'b0010,0,0,0,0), rbit(), rbit(), "decode");
        if (op == T_LW || op == T_SW) begin
            step(v(0,0,0,0,0,0,1,2'b10,4'b0010,0,0,0,0), rbit(), rbit(), "exec_mem");
            for (int i = 0; i < mw; i++)
                step(v(1,op==T_SW,1,0,0,0,0,2'b00,4'b0000,0,0,0,0), 1'b0, rbit(), "mem_wait");
            step(v(1,op==T_SW,1,0,0,0,0,2'b00,4'b0000,0,0,0,0), 1'b1, rbit(), "mem_ack");
            if (op == T_LW)
                step(v(0,0,0,0,0,0,0,2'b00,4'b0000,1,0,1,0), rbit(), rbit(), "wb_lw");
            lat = (op == T_LW) ? 5 + fw + mw : 4 + fw + mw;
            m_ret++;
        end else if (op == T_ADDI) begin
            step(v(0,0,0,0,0,0,1,2'b10,4'b0010,0,0,0,0), rbit(), rbit(), "exec_addi");
            step(v(0,0,0,0,0,0,0,2'b00,4'b0000,1,0,0,0), rbit(), rbit(), "wb_addi");
            lat = 4 + fw;
            m_ret++;
        end else if (op == T_R) begin
            step(v(0,0,0,0,0,0,1,2'b00,ins[3:0],0,0,0,0), rbit(), rbit(), "exec_r");
            step(v(0,0,0,0,0,0,0,2'b00,4'b0000,1,1,0,0), rbit(), rbit(), "wb_r");
            lat = 4 + fw;
            m_ret++;
        end else if (op == T_BEQ) begin
            step(v(0,0,0,0,zero,1,1,2'b00,4'b0110,0,0,0,0), rbit(), zero, "exec_beq");
            lat = 3 + fw;
            m_ret++;
        end else begin
            step(v(0,0,0,0,0,0,0,2'b00,4'b0000,0,0,0,1), rbit(), rbit(), "exec_illegal");
            lat = 3 + fw;
        end
        checks++;
        assert (ncyc == lat) else begin
            errors++;
            $error("FAIL latency: observed %0d expected %0d", ncyc, lat);
        end
        chk_ret("retired");
    endtask

    function automatic logic [31:0] rand_instr(input int cls);
        logic [31:0] r;
        logic [5:0]  op;
        r = $urandom();
        case (cls)
            0: op = T_LW;
            1: op = T_SW;
            2: op = T_ADDI;
            3: op = T_R;
            4: op = T_BEQ;
            default: begin
                op = 6'($urandom_range(0, 63));
                while (op == T_LW || op == T_SW || op == T_ADDI || op == T_R || op == T_BEQ)
                    op = 6'($urandom_range(0, 63));
            end
        endcase
        return {op, r[25:0]};
    endfunction

    logic [CW-1:0] snap;

    // Directed scenarios, then randomized instruction mix
    initial begin
        rst         = 1'b1;
        instruction = 32'h0;
        mem_ack     = 1'b0;
        alu_zero    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        assert (obs === 17'h0) else begin
            errors++;
            $error("FAIL reset_outputs: observed %h expected %h", obs, 17'h0);
        end
        chk_ret("reset_retired");
        rst = 1'b0;
        step(17'h0, 1'b1, 1'b1, "idle");

        // R-type add, zero-wait
        run_instr(32'h012A4020, 0, 0, 1'b0);
        // LW with 3 fetch waits and 2 memory waits (10 cycles)
        run_instr({T_LW, 26'h0221_0004}, 3, 2, 1'b0);
        // SW
        run_instr({T_SW, 26'h0231_0008}, 0, 1, 1'b0);
        // BEQ taken and not taken
        run_instr({T_BEQ, 26'h0109_0003}, 0, 0, 1'b1);
        run_instr({T_BEQ, 26'h0109_0003}, 0, 0, 1'b0);
        // Illegal opcode
        run_instr({6'b111111, 26'h0}, 0, 0, 1'b0);
        // ADDI
        run_instr({T_ADDI, 26'h0108_0005}, 1, 0, 1'b0);

        // Reset during a MEM wait
        instruction = {T_LW, 26'h0221_0004};
        step(v(1,0,0,1,1,0,0,2'b01,4'b0010,0,0,0,0), 1'b1, 1'b0, "abort_fetch");
        step(v(0,0,0,0,0,0,0,2'b11,4'b0010,0,0,0,0), 1'b0, 1'b0, "abort_decode");
        step(v(0,0,0,0,0,0,1,2'b10,4'b0010,0,0,0,0), 1'b0, 1'b0, "abort_exec");
        mem_ack = 1'b0;
        #4;
        checks++;
        assert (mem_req === 1'b1) else begin
            errors++;
            $error("FAIL abort_mem_req_before: observed %b expected 1", mem_req);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        assert (obs === 17'h0) else begin
            errors++;
            $error("FAIL abort_outputs: observed %h expected %h", obs, 17'h0);
        end
        m_ret = '0;
        chk_ret("abort_retired");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(17'h0, 1'b1, 1'b0, "abort_idle");

        // Randomized mix across all classes
        for (int n = 0; n < 40; n++)
            run_instr(rand_instr($urandom_range(0, 5)), $urandom_range(0, 3),
                      $urandom_range(0, 3), rbit());

        // Exactly 2^CW retires return the counter to its starting value
        snap = retired;
        for (int n = 0; n < 16; n++)
            run_instr(32'h012A4020, 0, 0, 1'b0);
        checks++;
        assert (retired === snap) else begin
            errors++;
            $error("FAIL wrap: observed %0d expected %0d", retired, snap);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule : tb_multicycle_ctrl
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath: replaces per-instruction combinational decode with an FSM that shares one ALU and one unified memory port across FETCH/DECODE/EXEC/MEM/WB.
- Drives PC/IR load strobes, ALU operand muxes, the memory request handshake and register-file write controls.
- Counts retired instructions.
- Sits between the IR/PC registers and the regfile/ALU/memory; decodes from the IR output.

Parameters:
CNT_W, 32, width of retired-instruction counter
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_RTYPE, 6'b000000, R-type opcode

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
instruction  in  32  current IR contents
mem_ack  in  1  memory completes the request this cycle
alu_zero  in  1  ALU zero flag
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write (SW)
i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR from memory read data
pc_write  out  1  load PC
pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut
alu_src_a  out  1  ALU A: 0 = PC, 1 = reg A
alu_src_b  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_ctrl  out  4  ALU operation
reg_write  out  1  regfile write enable
reg_dst  out  1  write register: 1 = rd [15:11], 0 = rt [20:16]
mem_to_reg  out  1  write data: 1 = memory, 0 = ALUOut
illegal  out  1  one-cycle pulse on an unknown opcode
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset and IDLE
  - rst high forces state IDLE and retired = 0.
  - In IDLE every output is 0. IDLE goes to FETCH unconditionally on the next clock.
  - rst asserted mid-operation aborts immediately. An outstanding mem_req drops in the same cycle via async reset.
- Output timing: outputs are combinational from state, opcode (instruction[31:26]), mem_ack and alu_zero (Mealy strobes noted below). All outputs not listed for a state are 0.
- FETCH
  - Drives mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=0010.
  - While mem_ack=0: stay in FETCH, ir_write=0, pc_write=0.
  - When mem_ack=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=0010 (branch target into ALUOut). Go to EXEC.
- EXEC, by opcode:
  - LW/SW/ADDI: alu_src_a=1, alu_src_b=10, alu_ctrl=0010.
    - LW/SW go to MEM.
    - ADDI goes to WB.
  - R-type: alu_src_a=1, alu_src_b=00, alu_ctrl=instruction[3:0]. Go to WB.
  - BEQ: alu_src_a=1, alu_src_b=00, alu_ctrl=0110, pc_src=1, pc_write=alu_zero. Retire; go to FETCH.
  - Any other opcode: illegal=1, no writes, no retire. Go to FETCH (PC already advanced).
- MEM
  - Drives mem_req=1, i_or_d=1, mem_we=(opcode==SW).
  - Hold until mem_ack.
  - On ack, SW retires and goes to FETCH; LW goes to WB.
  - mem_req and mem_we must stay stable while waiting.
- WB
  - reg_write=1 for one cycle.
  - R-type: reg_dst=1, mem_to_reg=0.
  - ADDI: reg_dst=0, mem_to_reg=0.
  - LW: reg_dst=0, mem_to_reg=1.
  - Retire; go to FETCH.
- Latency with zero-wait memory (mem_ack high in the request cycle):
  - BEQ 3 cycles; R/ADDI/SW 4; LW 5.
  - Each wait cycle adds 1.
- retired increments by 1 on the retire clock edge and wraps modulo 2^CNT_W without a flag.
- The opcode is sampled from instruction in DECODE/EXEC/MEM/WB. The IR is only written in FETCH, so it is stable throughout.

Decomposition:
- Shared package (mips_ctrl_pkg):
  - opcode constants;
  - ALU codes ALU_ADD=4'b0010, ALU_SUB=4'b0110;
  - alu_src_b encodings;
  - state enum IDLE/FETCH/DECODE/EXEC/MEM/WB.
- One sub-module, ctrl_decode: combinational opcode→class decode (is_lw, is_sw, is_beq, is_addi, is_r, is_bad). The FSM and counter stay in multicycle_ctrl.

Test Plan:
- Reset, then R-type add (instruction=32'h012A4020, funct 0000), mem_ack tied 1:
  - cycle 1 IDLE with all outputs 0;
  - FETCH/DECODE/EXEC(alu_ctrl=0000)/WB(reg_write=1, reg_dst=1);
  - retired=1 after 4 cycles.
- LW with mem_ack delayed 3 cycles in FETCH and 2 in MEM:
  - mem_req held high throughout the waits, i_or_d=1 in MEM;
  - WB has mem_to_reg=1, reg_dst=0;
  - total 10 cycles; retired increments once.
- SW: MEM shows mem_we=1, mem_req=1; no reg_write in any cycle; next state FETCH.
- BEQ run twice:
  - alu_zero=1 → pc_write=1, pc_src=1 in EXEC;
  - alu_zero=0 → pc_write=0;
  - both retire in 3 cycles.
- Opcode 6'b111111: illegal pulses exactly 1 cycle in EXEC, retired unchanged, next state FETCH.
- Boundaries:
  - rst asserted during a MEM wait → mem_req falls within the cycle, then IDLE, retired=0;
  - CNT_W=4 → after 16 retires, retired=0.
